pif_led_breather: RTL
=====================

Name: pif_led_breather

Overview:
- Multi-channel successor to the single red/green flasher.
- Drives NCH LED outputs with sigma-delta PWM "breathing" (ramp up, then ramp down) paced by a runtime-programmable tick divider.
- Four runtime modes: off, solid, sequential breathing (one channel at a time), and all-channel breathing.
- Sits next to the on-chip oscillator and drives board LED pins directly.

Parameters:
- NCH, 2: number of LED channels, 1..16; need not be a power of 2.
- B, 5: brightness resolution in bits.
- DIV_W, 18: width of the tick divider value.
- ACTIVE_LOW, 1: 1 = LED pin is low when lit; 0 = high when lit.

Ports:
- Clk  input  1  oscillator clock.
- sys_rst  input  1  asynchronous reset, active-low.
- div_val  input  DIV_W  tick period minus 1, in Clk cycles; sampled only at counter reload.
- mode  input  2  0=OFF, 1=SOLID, 2=SEQ, 3=ALL.
- led  output  NCH  LED drive; polarity set by ACTIVE_LOW.
- tick  output  1  single-cycle pulse, once per tick period.
- chan_idx  output  max(1,clog2(NCH))  channel currently breathing.

Behaviour:
- Reset (sys_rst low, asynchronous): all registers clear; led = all-inactive (all 1s when ACTIVE_LOW=1), tick=0, chan_idx=0, level=0, dir=0, acc=0.

Tick divider:
- Down-counter, reset value 0.
- When the count is 0: tick=1 and the counter reloads div_val. Otherwise it decrements.
- Resulting period is div_val+1 cycles; div_val=0 gives tick every cycle.
- A change on div_val takes effect at the next reload.

Step counters (advance only on tick, only in SEQ/ALL):
- level (B bits) increments.
- On level wrap 2^B-1 -> 0: dir toggles.
- On the wrap where dir goes 1 -> 0: chan_idx increments; at NCH-1 it wraps to 0.

Duty and modulator:
- duty = dir ? (2^B-1-level) : level, B bits.
- Accumulator acc is B+1 bits. On tick: acc <= 0. Otherwise: acc <= {0, acc[B-1:0]} + {0, duty}.
- on = acc[B]; registered to led one cycle later.
- Lit cycles per tick period = floor(div_val*duty/2^B), exact for div_val+1 >= 2^B.

Modes:
- OFF: led all inactive; level, dir and chan_idx held at 0; divider keeps running.
- SOLID: led all active; counters hold their values.
- SEQ: led[chan_idx] follows on; all other channels inactive.
- ALL: every led bit follows on; chan_idx still advances but does not gate output.
- A mode change takes effect on led 1 cycle after mode changes.
- Leaving OFF restarts breathing from level=0, dir=0, chan_idx=0.

Boundary cases:
- NCH=1: chan_idx is a constant 0.
- Tick and level wrap coincide: dir toggles and acc clears in the same cycle.
- Reset asserted mid-ramp: immediate return to reset values; no glitch on led beyond the async clear.

Optional Feature:
- PIF_LED_GAMMA_EN defined: duty = (lin*lin) >> B, where lin is the linear duty above; integer, truncating. Gives perceptually smoother fades.
- Macro absent: duty = lin (linear). No squarer logic is synthesised.

Decomposition:
- Shared package pif_led_pkg:
  - mode encodings MODE_OFF=0, MODE_SOLID=1, MODE_SEQ=2, MODE_ALL=3.
  - clog2 helper function.
- Sub-module pif_tick_div (parameter DIV_W; ports Clk, sys_rst, div_val, tick):
  - reusable divider, replaces the old fixed-constant down-counter.

Test Plan:
- Reset, B=5, NCH=2, ACTIVE_LOW=1, div_val=31, mode=OFF: led=2'b11; tick every 32 cycles; chan_idx=0.
- mode=SOLID: led=2'b00 starting 1 cycle after the mode change; level frozen.
- mode=SEQ, force level=16, dir=0 (duty 16): led[0] low for 15 of 32 cycles per period; led[1] stays 1.
- mode=SEQ over 64 ticks: dir toggles at tick 32; chan_idx goes 0 -> 1 at tick 64; NCH=3 wraps 2 -> 0 after 192 ticks.
- mode=ALL, div_val=0: tick every cycle; both leds identical; change div_val to 7 mid-count and check the new period only after the next reload.
- Assert sys_rst mid-ramp (level=20, dir=1): led, tick, chan_idx return to reset values asynchronously; after release, breathing restarts from level 0.

Source files
------------

// File: rtl/pif_led_pkg.sv
// Shared definitions for the LED breather: mode encodings and width helpers.
package pif_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_SEQ   = 2'd2,
        MODE_ALL   = 2'd3
    } mode_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pif_tick_div.sv
// Programmable tick divider: one-cycle pulse every div_val+1 cycles.
module pif_tick_div #(
    parameter int DIV_W = 18
) (
    input  logic             Clk,
    input  logic             sys_rst,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Pulse is registered off the zero count so it reads 0 while in reset;
    // the period is unchanged at div_val+1.
    always_comb begin
        tick_d = (cnt_q == '0);
        cnt_d  = tick_d ? div_val : cnt_q - DIV_W'(1);
    end

    always_ff @(posedge Clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pif_led_breather.sv
// Multi-channel sigma-delta LED breather with OFF/SOLID/SEQ/ALL modes.
// Define PIF_LED_GAMMA_EN for squared (gamma) duty instead of linear.
module pif_led_breather
    import pif_led_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int B          = 5,
    parameter int DIV_W      = 18,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      Clk,
    input  logic                      sys_rst,
    input  logic [DIV_W-1:0]          div_val,
    input  logic [1:0]                mode,
    output logic [NCH-1:0]            led,
    output logic                      tick,
    output logic [chan_w(NCH)-1:0]    chan_idx
);

    localparam int CW = chan_w(NCH);

    mode_e          m;
    logic [B-1:0]   level_q, level_d;
    logic           dir_q, dir_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic [B:0]     acc_q, acc_d;
    logic [NCH-1:0] led_q, led_d;
    logic [NCH-1:0] lit;
    logic [B-1:0]   lin, duty;
    logic           on;

    pif_tick_div #(.DIV_W(DIV_W)) u_div (
        .Clk     (Clk),
        .sys_rst (sys_rst),
        .div_val (div_val),
        .tick    (tick)
    );

    assign m = mode_e'(mode);

    always_comb begin
        level_d = level_q;
        dir_d   = dir_q;
        chan_d  = chan_q;
        case (m)
            MODE_OFF: begin
                level_d = '0;
                dir_d   = 1'b0;
                chan_d  = '0;
            end
            MODE_SEQ, MODE_ALL: begin
                if (tick) begin
                    level_d = level_q + B'(1);
                    if (level_q == '1) begin
                        dir_d = ~dir_q;
                        if (dir_q) chan_d = (chan_q == CW'(NCH - 1)) ? '0 : chan_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign lin = dir_q ? ~level_q : level_q;

`ifdef PIF_LED_GAMMA_EN
    logic [2*B-1:0] sq;
    assign sq   = lin * lin;
    assign duty = sq[2*B-1:B];
`else
    assign duty = lin;
`endif

    assign acc_d = tick ? '0 : {1'b0, acc_q[B-1:0]} + {1'b0, duty};
    assign on    = acc_q[B];

    always_comb begin
        lit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            case (m)
                MODE_SOLID: lit[i] = 1'b1;
                MODE_SEQ:   lit[i] = on && (chan_q == CW'(i));
                MODE_ALL:   lit[i] = on;
                default:    lit[i] = 1'b0;
            endcase
        end
        led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

    always_ff @(posedge Clk or negedge sys_rst) begin
        if (!sys_rst) begin
            level_q <= '0;
            dir_q   <= 1'b0;
            chan_q  <= '0;
            acc_q   <= '0;
            led_q   <= {NCH{ACTIVE_LOW != 0}};
        end else begin
            level_q <= level_d;
            dir_q   <= dir_d;
            chan_q  <= chan_d;
            acc_q   <= acc_d;
            led_q   <= led_d;
        end
    end

    assign led      = led_q;
    assign chan_idx = chan_q;

endmodule
